// File: rtl/jump_ctrl.sv
// Program counter and conditional-jump unit: PC fetch advance, status snapshot,
// condition evaluation and two-byte absolute jump. Define JMP_REL_EN for one-byte relative jumps.
module jump_ctrl #(
    parameter int unsigned NumStatusBits = 3,
    parameter int unsigned AddrWidth     = 12
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic [NumStatusBits-1:0] status,
    input  logic                     pc_inc,
    input  logic                     jmp_req,
    input  logic [2:0]               cond,
    input  logic [7:0]               addr_byte,
    input  logic                     addr_valid,
`ifdef JMP_REL_EN
    input  logic                     rel,
`endif
    output logic [AddrWidth-1:0]     pc,
    output logic                     busy,
    output logic                     done,
    output logic                     taken
);

    localparam int unsigned HiBits = AddrWidth - 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_UPD  = 2'd3
    } state_t;

    state_t                   state_q;
    state_t                   state_next;
    logic                     busy_d;
    logic                     done_d;
    logic                     taken_d;
    logic [2:0]               cond_q;
    logic [NumStatusBits-1:0] stat_q;
    logic [7:0]               lo_q;
    logic [HiBits-1:0]        hi_q;
    logic                     cond_true_c;
    logic                     rel_mode_c;
    logic [AddrWidth-1:0]     target_c;
    logic [AddrWidth-1:0]     pc_plus1_c;

`ifdef JMP_REL_EN
    logic                     rel_q;
    assign rel_mode_c = rel_q;
`else
    assign rel_mode_c = 1'b0;
`endif

    assign pc_plus1_c = pc + AddrWidth'(1);

    // Condition evaluated on the status snapshot taken with jmp_req
    always_comb begin
        cond_true_c = 1'b0;
        case (cond_q)
            3'b000:  cond_true_c = 1'b1;
            3'b001:  cond_true_c = stat_q[1];
            3'b010:  cond_true_c = ~stat_q[1];
            3'b011:  cond_true_c = stat_q[0];
            3'b100:  cond_true_c = ~stat_q[0];
            3'b101:  cond_true_c = stat_q[2];
            3'b110:  cond_true_c = ~stat_q[2];
            default: cond_true_c = 1'b0;
        endcase
    end

    // Jump target: relative adds the sign-extended operand to the post-operand PC
    always_comb begin
        target_c = {hi_q, lo_q};
        if (rel_mode_c) begin
            target_c = pc + {{(AddrWidth-8){lo_q[7]}}, lo_q};
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            taken   <= 1'b0;
        end else begin
            state_q <= state_next;
            busy    <= busy_d;
            done    <= done_d;
            taken   <= taken_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE: if (jmp_req) state_next = ST_LO;
            ST_LO:   if (addr_valid) state_next = rel_mode_c ? ST_UPD : ST_HI;
            ST_HI:   if (addr_valid) state_next = ST_UPD;
            ST_UPD:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output values for the upcoming state, registered above
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        taken_d = 1'b0;
        if (state_next != ST_IDLE) begin
            busy_d = 1'b1;
        end
        if (state_next == ST_UPD) begin
            done_d  = 1'b1;
            taken_d = cond_true_c;
        end
    end

    // PC and operand latches
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pc     <= '0;
            cond_q <= '0;
            stat_q <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
`ifdef JMP_REL_EN
            rel_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (jmp_req) begin
                        cond_q <= cond;
                        stat_q <= status;
`ifdef JMP_REL_EN
                        rel_q  <= rel;
`endif
                        pc     <= pc_plus1_c;
                    end else if (pc_inc) begin
                        pc     <= pc_plus1_c;
                    end
                end
                ST_LO: begin
                    if (addr_valid) begin
                        lo_q <= addr_byte;
                        pc   <= pc_plus1_c;
                    end
                end
                ST_HI: begin
                    if (addr_valid) begin
                        hi_q <= addr_byte[HiBits-1:0];
                        pc   <= pc_plus1_c;
                    end
                end
                ST_UPD: begin
                    if (taken) begin
                        pc <= target_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed self-checking bench for jump_ctrl (default 12-bit PC; relative jump
// exercised when JMP_REL_EN is defined).
module tb_jump_ctrl;

    logic        clk;
    logic        res_n;
    logic [2:0]  status;
    logic        pc_inc;
    logic        jmp_req;
    logic [2:0]  cond;
    logic [7:0]  addr_byte;
    logic        addr_valid;
`ifdef JMP_REL_EN
    logic        rel;
`endif
    logic [11:0] pc;
    logic        busy;
    logic        done;
    logic        taken;

    int checks = 0;
    int errors = 0;

    jump_ctrl #(.NumStatusBits(3), .AddrWidth(12)) dut (
        .clk        (clk),
        .res_n      (res_n),
        .status     (status),
        .pc_inc     (pc_inc),
        .jmp_req    (jmp_req),
        .cond       (cond),
        .addr_byte  (addr_byte),
        .addr_valid (addr_valid),
`ifdef JMP_REL_EN
        .rel        (rel),
`endif
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .taken      (taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Absolute jump from pc0 with both operand bytes valid immediately
    task automatic jump(input string tag, input logic [2:0] c, input logic [2:0] st,
                        input logic [7:0] lo, input logic [7:0] hi,
                        input logic [11:0] pc0, input logic exp_tk, input logic [11:0] exp_pc);
        status  = st;
        cond    = c;
        jmp_req = 1'b1;
        step();
        jmp_req = 1'b0;
        chk({tag, "_lo_pc"}, 32'(pc), 32'(pc0 + 12'd1));
        chk({tag, "_lo_busy"}, 32'(busy), 32'd1);
        addr_valid = 1'b1;
        addr_byte  = lo;
        step();
        chk({tag, "_hi_pc"}, 32'(pc), 32'(pc0 + 12'd2));
        addr_byte = hi;
        step();
        addr_valid = 1'b0;
        chk({tag, "_upd_done"}, 32'(done), 32'd1);
        chk({tag, "_upd_taken"}, 32'(taken), 32'(exp_tk));
        chk({tag, "_upd_pc"}, 32'(pc), 32'(pc0 + 12'd3));
        step();
        chk({tag, "_end_pc"}, 32'(pc), 32'(exp_pc));
        chk({tag, "_end_busy"}, 32'(busy), 32'd0);
        chk({tag, "_end_done"}, 32'(done), 32'd0);
        chk({tag, "_end_taken"}, 32'(taken), 32'd0);
    endtask

    initial begin
        res_n      = 1'b0;
        status     = '0;
        pc_inc     = 1'b0;
        jmp_req    = 1'b0;
        cond       = '0;
        addr_byte  = '0;
        addr_valid = 1'b0;
`ifdef JMP_REL_EN
        rel        = 1'b0;
`endif
        step();
        step();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_taken", 32'(taken), 32'd0);
        res_n = 1'b1;

        // Five fetch strobes
        pc_inc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("inc_done", 32'(done), 32'd0);
        end
        pc_inc = 1'b0;
        chk("inc_pc5", 32'(pc), 32'd5);
        chk("inc_busy", 32'(busy), 32'd0);

        pc_inc = 1'b1;
        repeat (11) step();
        pc_inc = 1'b0;
        chk("inc_pc16", 32'(pc), 32'h010);

        // Z=1 taken, then Z=0 not taken (skips three bytes from 0x234)
        jump("jz_tk", 3'b001, 3'b010, 8'h34, 8'h02, 12'h010, 1'b1, 12'h234);
        jump("jz_nt", 3'b001, 3'b000, 8'h34, 8'h02, 12'h234, 1'b0, 12'h237);

        // Snapshot: C=1 at request, cleared during LO; strobes ignored while busy
        status  = 3'b001;
        cond    = 3'b011;
        jmp_req = 1'b1;
        step();
        chk("snap_lo_pc", 32'(pc), 32'h238);
        status = 3'b000;
        pc_inc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("snap_wait_pc", 32'(pc), 32'h238);
            chk("snap_wait_busy", 32'(busy), 32'd1);
            chk("snap_wait_done", 32'(done), 32'd0);
        end
        jmp_req    = 1'b0;
        pc_inc     = 1'b0;
        addr_valid = 1'b1;
        addr_byte  = 8'h56;
        step();
        chk("snap_hi_pc", 32'(pc), 32'h239);
        addr_byte = 8'h07;
        jmp_req   = 1'b1;
        pc_inc    = 1'b1;
        step();
        jmp_req    = 1'b0;
        pc_inc     = 1'b0;
        addr_valid = 1'b0;
        chk("snap_done", 32'(done), 32'd1);
        chk("snap_taken", 32'(taken), 32'd1);
        chk("snap_upd_pc", 32'(pc), 32'h23A);
        step();
        chk("snap_pc", 32'(pc), 32'h756);
        chk("snap_busy", 32'(busy), 32'd0);

        // High byte 0xFF truncated to 0xF, then fetch wraps 0xFFF -> 0
        jump("jabs_ff", 3'b000, 3'b000, 8'hFF, 8'hFF, 12'h756, 1'b1, 12'hFFF);
        pc_inc = 1'b1;
        step();
        pc_inc = 1'b0;
        chk("wrap_pc", 32'(pc), 32'h000);

        // cond 111 never taken even with every flag set; N=1 with cond 101 taken
        jump("never", 3'b111, 3'b111, 8'h00, 8'h00, 12'h000, 1'b0, 12'h003);
        jump("jn_tk", 3'b101, 3'b100, 8'hAB, 8'h0C, 12'h003, 1'b1, 12'hCAB);
        jump("jnc_nt", 3'b100, 3'b001, 8'h11, 8'h01, 12'hCAB, 1'b0, 12'hCAE);

        // Asynchronous reset while in HI
        cond    = 3'b000;
        jmp_req = 1'b1;
        step();
        jmp_req    = 1'b0;
        addr_valid = 1'b1;
        addr_byte  = 8'h99;
        step();
        addr_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        res_n = 1'b0;
        #1;
        chk("mid_rst_pc", 32'(pc), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        step();
        res_n = 1'b1;
        step();
        chk("post_rst_pc", 32'(pc), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

`ifdef JMP_REL_EN
        // pc 0x100 after the opcode, 0x101 after the operand, minus 2 -> 0x0FF
        jump("rel_setup", 3'b000, 3'b000, 8'hFF, 8'h00, 12'h000, 1'b1, 12'h0FF);
        rel     = 1'b1;
        jmp_req = 1'b1;
        step();
        jmp_req = 1'b0;
        rel     = 1'b0;
        chk("rel_lo_pc", 32'(pc), 32'h100);
        addr_valid = 1'b1;
        addr_byte  = 8'hFE;
        step();
        addr_valid = 1'b0;
        chk("rel_done", 32'(done), 32'd1);
        chk("rel_taken", 32'(taken), 32'd1);
        chk("rel_upd_pc", 32'(pc), 32'h101);
        step();
        chk("rel_pc", 32'(pc), 32'h0FF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
